// File: rtl/rx_frame_ring_writer.sv
// Receive path: packs 64-bit MAC rx beats into a 2^BW-word ring and publishes each frame behind a
// one-word length header. Optional build macro: RX_TIMESTAMP_EN stamps header[31:0] with the SOF cycle count.
module rx_frame_ring_writer #(
   parameter int BW      = 10,
   parameter int GUARD   = 6,
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1518
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [63:0]   mac_rx_data,
   input  logic [7:0]    mac_rx_data_valid,
   input  logic          mac_rx_good_frame,
   input  logic          mac_rx_bad_frame,
   output logic          wr_en,
   output logic [BW-1:0] wr_addr,
   output logic [63:0]   wr_data,
   output logic [BW-1:0] committed_prod,
   input  logic [BW-1:0] committed_cons,
   output logic          activity,
   output logic [15:0]   ovf_drops,
   output logic [15:0]   len_drops,
   output logic [15:0]   bad_frames,
   output logic [2:0]    fsm_state
);

   // Handshake: the MAC side has no backpressure, a beat is taken every cycle its mask is nonzero.
   // wr_en is a fire-and-forget strobe. committed_prod moves (with a one-cycle activity pulse)
   // only on a cycle strictly after the header write, so anything below it is fully written.

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_IDLE = 3'd1,
      S_RX   = 3'd2,
      S_HDR  = 3'd3,
      S_DROP = 3'd4
   } state_t;

   localparam logic [BW:0] SPACE_LIMIT = (BW+1)'((1 << BW) - GUARD);

   state_t        state, state_n;
   logic [BW-1:0] aux_addr, aux_addr_n;
   logic [BW-1:0] head, head_n;
   logic [16:0]   len, len_n;
   logic          drop_ovf, drop_ovf_n;
   logic          hdr_late, hdr_late_n;
   logic          commit_pend, commit_pend_n;
   logic          wr_en_n;
   logic [BW-1:0] wr_addr_n;
   logic [63:0]   wr_data_n;
   logic [BW-1:0] committed_prod_n;
   logic          activity_n;
   logic          inc_ovf, inc_len, inc_bad;

   logic [3:0]    beat_bytes;
   logic          has_data, eof, good_eof, in_idle;
   logic [BW-1:0] beat_addr, space_diff;
   logic [16:0]   len_sum;
   logic          space_fail, too_long, runt;
   logic [31:0]   sof_ts, frame_ts;

   function automatic logic [63:0] hdr_word(input logic [15:0] l, input logic [31:0] ts);
      return {16'h0000, l, ts};
   endfunction

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < 8; i++) beat_bytes = beat_bytes + 4'(mac_rx_data_valid[i]);
   end

   assign has_data   = |mac_rx_data_valid;
   assign eof        = mac_rx_good_frame | mac_rx_bad_frame;
   assign good_eof   = mac_rx_good_frame & ~mac_rx_bad_frame;
   assign in_idle    = (state == S_IDLE);
   assign beat_addr  = in_idle ? head + BW'(1) : aux_addr;
   assign len_sum    = (in_idle ? 17'd0 : len) + 17'(beat_bytes);
   assign space_diff = beat_addr - committed_cons;
   assign space_fail = has_data && ({1'b0, space_diff} > SPACE_LIMIT);
   assign too_long   = len_sum > 17'(MAX_LEN);
   assign runt       = len_sum < 17'(MIN_LEN);
   assign fsm_state  = state;

`ifdef RX_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt   <= '0;
         frame_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (in_idle && has_data) frame_ts <= ts_cnt;
      end
   end

   assign sof_ts = in_idle ? ts_cnt : frame_ts;
`else
   assign frame_ts = '0;
   assign sof_ts   = '0;
`endif

   always_comb begin
      state_n          = state;
      aux_addr_n       = aux_addr;
      head_n           = head;
      len_n            = len;
      drop_ovf_n       = drop_ovf;
      hdr_late_n       = hdr_late;
      commit_pend_n    = 1'b0;
      wr_en_n          = 1'b0;
      wr_addr_n        = wr_addr;
      wr_data_n        = wr_data;
      committed_prod_n = committed_prod;
      activity_n       = 1'b0;
      inc_ovf          = 1'b0;
      inc_len          = 1'b0;
      inc_bad          = 1'b0;

      // Second half of a delayed header: publish one cycle after it was written.
      if (commit_pend) begin
         committed_prod_n = head;
         activity_n       = 1'b1;
      end

      unique case (state)
         S_SYNC: begin
            if (!has_data) state_n = S_IDLE;
         end
         S_IDLE, S_RX: begin
            if (in_idle && !has_data) begin
               len_n = '0;
            end else begin
               len_n = len_sum;
               if (space_fail) begin
                  if (eof) begin
                     inc_ovf = 1'b1;
                     state_n = S_IDLE;
                  end else begin
                     drop_ovf_n = 1'b1;
                     state_n    = S_DROP;
                  end
               end else if (too_long) begin
                  if (eof) begin
                     inc_len = 1'b1;
                     state_n = S_IDLE;
                  end else begin
                     drop_ovf_n = 1'b0;
                     state_n    = S_DROP;
                  end
               end else begin
                  aux_addr_n = beat_addr;
                  if (has_data) begin
                     wr_en_n    = 1'b1;
                     wr_addr_n  = beat_addr;
                     wr_data_n  = mac_rx_data;
                     aux_addr_n = beat_addr + BW'(1);
                  end
                  if (good_eof) begin
                     if (runt) begin
                        inc_len = 1'b1;
                        state_n = S_IDLE;
                     end else begin
                        state_n = S_HDR;
                        // The write port is busy with the last data word; header goes out next cycle.
                        hdr_late_n = has_data;
                        if (!has_data) begin
                           wr_en_n   = 1'b1;
                           wr_addr_n = head;
                           wr_data_n = hdr_word(len_sum[15:0], sof_ts);
                        end
                     end
                  end else if (eof) begin
                     inc_bad = 1'b1;
                     state_n = S_IDLE;
                  end else begin
                     state_n = S_RX;
                  end
               end
            end
         end
         S_HDR: begin
            head_n = aux_addr;
            if (hdr_late) begin
               wr_en_n       = 1'b1;
               wr_addr_n     = head;
               wr_data_n     = hdr_word(len[15:0], frame_ts);
               commit_pend_n = 1'b1;
            end else begin
               committed_prod_n = aux_addr;
               activity_n       = 1'b1;
            end
            // A beat here broke the inter-frame gap: that new frame is discarded as overflow.
            if (has_data) begin
               if (eof) begin
                  inc_ovf = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  drop_ovf_n = 1'b1;
                  state_n    = S_DROP;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_DROP: begin
            if (eof) begin
               inc_ovf = drop_ovf;
               inc_len = ~drop_ovf;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_SYNC;
         aux_addr       <= '0;
         head           <= '0;
         len            <= '0;
         drop_ovf       <= 1'b0;
         hdr_late       <= 1'b0;
         commit_pend    <= 1'b0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         committed_prod <= '0;
         activity       <= 1'b0;
         ovf_drops      <= '0;
         len_drops      <= '0;
         bad_frames     <= '0;
      end else begin
         state          <= state_n;
         aux_addr       <= aux_addr_n;
         head           <= head_n;
         len            <= len_n;
         drop_ovf       <= drop_ovf_n;
         hdr_late       <= hdr_late_n;
         commit_pend    <= commit_pend_n;
         wr_en          <= wr_en_n;
         wr_addr        <= wr_addr_n;
         wr_data        <= wr_data_n;
         committed_prod <= committed_prod_n;
         activity       <= activity_n;
         if (inc_ovf && ovf_drops != 16'hFFFF)  ovf_drops  <= ovf_drops + 16'd1;
         if (inc_len && len_drops != 16'hFFFF)  len_drops  <= len_drops + 16'd1;
         if (inc_bad && bad_frames != 16'hFFFF) bad_frames <= bad_frames + 16'd1;
      end
   end

endmodule
